pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 8'h00: PC value after reset.
REQ-002 SHALL have parameter DEPTH, default 4: return-stack entries, legal range 2..8.
REQ-003 SHALL have port clk, input, 1: sole clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1: when 1, all state holds and every op is ignored.
REQ-006 SHALL have port inc, input, 1: advance PC by 1.
REQ-007 SHALL have port load, input, 1: jump, PC <= target.
REQ-008 SHALL have port call, input, 1: push PC+1, then PC <= target.
REQ-009 SHALL have port ret, input, 1: PC <= popped address.
REQ-010 SHALL have port target, input, 8: jump/call destination.
REQ-011 SHALL have port pc, output, 8: registered program counter, the address-side data input of the downstream 2:1 address mux.
REQ-012 SHALL have port stack_empty, output, 1: registered, 1 when stack pointer = 0.
REQ-013 SHALL have port stack_full, output, 1: registered, 1 when stack pointer = DEPTH.
REQ-014 SHALL have port fault, output, 1: sticky stack-error flag (see Configuration).

Function
REQ-015 SHALL sample ops on the rising clk edge; the pc, stack_empty and stack_full effects SHALL be visible one cycle after the op is sampled (latency 1), with no combinational path from input to output.
REQ-016 SHALL resolve simultaneous ops by fixed priority ret > call > load > inc; lower-priority ops in the same cycle are discarded.
REQ-017 SHALL hold pc when no op is asserted, or when stall=1 (stall overrides everything except rst).
REQ-018 SHALL perform inc as pc <= pc+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-019 SHALL, on call with stack not full, write (pc+1) mod 256 at stack[sp], set sp <= sp+1, and set pc <= target in the same edge.
REQ-020 SHALL, on ret with stack not empty, set pc <= stack[sp-1] and sp <= sp-1.
REQ-021 SHALL keep sp in 0..DEPTH, using $clog2(DEPTH+1) bits; a LIFO order violation is a bug.
REQ-022 SHALL hold a control state machine of two states: RUN (ops executed) and HALT (all ops ignored, pc frozen); HALT SHALL be reachable only under the fault behaviour defined in REQ-028.
REQ-023 SHALL NOT reset stack contents; only sp is cleared, so stale entries are unreachable.

Reset
REQ-024 SHALL, on rst=1 at any time including mid-operation, asynchronously force pc=RESET_VECTOR, sp=0, stack_empty=1, stack_full=0, fault=0, state=RUN.
REQ-025 SHALL resume normal operation on the first rising edge after rst deasserts; an op present on that edge SHALL be executed.

Configuration
REQ-026 SHALL gate stack-error trapping with macro PC_STACK_FAULT_EN.
REQ-027 Without PC_STACK_FAULT_EN: a call on a full stack SHALL jump to target and discard the push (sp unchanged); a ret on an empty stack SHALL load RESET_VECTOR; fault SHALL be constant 0; HALT SHALL be unreachable.
REQ-028 With PC_STACK_FAULT_EN: a call on a full stack or a ret on an empty stack SHALL leave pc and sp unchanged, set fault=1 on that edge, and enter HALT; pc and fault SHALL then hold until rst.

Verification
REQ-029 SHALL cover reset with RESET_VECTOR=8'h10: assert rst asynchronously mid-stream -> pc=8'h10, stack_empty=1, fault=0 with no clock edge required.
REQ-030 SHALL cover wrap: load target=8'hFE, then inc x3 -> pc sequence 8'hFE, 8'hFF, 8'h00, 8'h01.
REQ-031 SHALL cover nesting, starting from pc=8'h05: call 8'h40, call 8'h80, ret, ret -> pc sequence 8'h40, 8'h80, 8'h41, 8'h06, ending with stack_empty=1.
REQ-032 SHALL cover priority and stall: ret+call+inc together with 1 entry holding 8'h22 -> pc=8'h22; then stall=1 with inc for 3 cycles -> pc held at 8'h22.
REQ-033 SHALL cover overflow with DEPTH=4: 5 calls to 8'h30 -> stack_full=1 after the 4th; 5th call gives pc=8'h30 and fault=0 without the macro, or pc unchanged, fault=1 and all further ops ignored with the macro.
REQ-034 SHALL cover underflow: ret on empty stack -> pc=RESET_VECTOR without the macro, or fault=1 and HALT with the macro; a following rst clears fault.

Source files
------------

// File: rtl/pc_sequencer.sv
// =============================================================================
// Module  : pc_sequencer
// Brief   : 8-bit program counter with call/return stack and RUN/HALT control.
//           Optional stack-error trapping enabled by macro PC_STACK_FAULT_EN.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module pc_sequencer #(
    parameter logic [7:0] RESET_VECTOR = 8'h00,
    parameter int         DEPTH        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       inc,
    input  logic       load,
    input  logic       call,
    input  logic       ret,
    input  logic [7:0] target,
    output logic [7:0] pc,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       fault
);

    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = $clog2(DEPTH);
    localparam logic [SPW-1:0] c_sp_full = SPW'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    logic [7:0]     r_stack [DEPTH];
    logic [7:0]     r_pc;
    logic [SPW-1:0] r_sp;
    logic           r_empty;
    logic           r_full;
    state_t         r_state;

    logic [7:0]     w_pc_nxt;
    logic [7:0]     w_pc_inc;
    logic [7:0]     w_top;
    logic [SPW-1:0] w_sp_nxt;
    logic [SPW-1:0] w_sp_inc;
    logic [SPW-1:0] w_sp_dec;
    logic           w_push;
    logic           w_trap;
    logic           w_is_empty;
    logic           w_is_full;

    assign w_pc_inc   = r_pc + 8'd1;
    assign w_sp_inc   = r_sp + SPW'(1);
    assign w_sp_dec   = r_sp - SPW'(1);
    assign w_top      = r_stack[w_sp_dec[IDXW-1:0]];
    assign w_is_empty = (r_sp == '0);
    assign w_is_full  = (r_sp == c_sp_full);

    // Op decode: ret > call > load > inc; stall or HALT freezes everything.
    always_comb begin
        w_pc_nxt = r_pc;
        w_sp_nxt = r_sp;
        w_push   = 1'b0;
        w_trap   = 1'b0;
        if (!stall && (r_state == ST_RUN)) begin
            if (ret) begin
                if (!w_is_empty) begin
                    w_pc_nxt = w_top;
                    w_sp_nxt = w_sp_dec;
                end else begin
`ifdef PC_STACK_FAULT_EN
                    w_trap   = 1'b1;
`else
                    w_pc_nxt = RESET_VECTOR;
`endif
                end
            end else if (call) begin
                if (!w_is_full) begin
                    w_push   = 1'b1;
                    w_sp_nxt = w_sp_inc;
                    w_pc_nxt = target;
                end else begin
`ifdef PC_STACK_FAULT_EN
                    w_trap   = 1'b1;
`else
                    w_pc_nxt = target;
`endif
                end
            end else if (load) begin
                w_pc_nxt = target;
            end else if (inc) begin
                w_pc_nxt = w_pc_inc;
            end
        end
    end

    // Stack storage is deliberately not reset; clearing sp makes old entries unreachable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_sp[IDXW-1:0]] <= w_pc_inc;
        end
    end

`ifdef PC_STACK_FAULT_EN
    logic r_fault;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_VECTOR;
            r_sp    <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_state <= ST_RUN;
`ifdef PC_STACK_FAULT_EN
            r_fault <= 1'b0;
`endif
        end else begin
            r_pc    <= w_pc_nxt;
            r_sp    <= w_sp_nxt;
            r_empty <= (w_sp_nxt == '0);
            r_full  <= (w_sp_nxt == c_sp_full);
            if (w_trap) begin
                r_state <= ST_HALT;
            end
`ifdef PC_STACK_FAULT_EN
            if (w_trap) begin
                r_fault <= 1'b1;
            end
`endif
        end
    end

    assign pc          = r_pc;
    assign stack_empty = r_empty;
    assign stack_full  = r_full;
`ifdef PC_STACK_FAULT_EN
    assign fault       = r_fault;
`else
    assign fault       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// =============================================================================
// Module  : tb_pc_sequencer
// Brief   : Directed + randomized bench for pc_sequencer against a queue-based
//           reference model (follows PC_STACK_FAULT_EN when defined).
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam logic [7:0] RV    = 8'h10;
    localparam int         DEPTH = 4;
`ifdef PC_STACK_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       inc = 1'b0;
    logic       load = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] target = 8'h00;
    logic [7:0] pc;
    logic       stack_empty;
    logic       stack_full;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    // Reference model: return addresses in a queue, pc as plain integer.
    int         m_pc = RV;
    logic [7:0] m_q[$];
    bit         m_fault = 1'b0;
    bit         m_halt  = 1'b0;

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .DEPTH        (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .inc         (inc),
        .load        (load),
        .call        (call),
        .ret         (ret),
        .target      (target),
        .pc          (pc),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk8({tag, "/pc"}, pc, 8'(m_pc));
        chk1({tag, "/empty"}, stack_empty, m_q.size() == 0);
        chk1({tag, "/full"}, stack_full, m_q.size() == DEPTH);
        chk1({tag, "/fault"}, fault, m_fault);
    endtask

    task automatic model_reset();
        m_pc = RV;
        m_q.delete();
        m_fault = 1'b0;
        m_halt  = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit c, input bit l, input bit i,
                              input bit s, input logic [7:0] t);
        if (s || m_halt) return;
        if (r) begin
            if (m_q.size() > 0) m_pc = m_q.pop_back();
            else if (FAULT_EN) begin m_fault = 1'b1; m_halt = 1'b1; end
            else m_pc = RV;
        end else if (c) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(8'((m_pc + 1) % 256));
                m_pc = t;
            end else if (FAULT_EN) begin
                m_fault = 1'b1; m_halt = 1'b1;
            end else m_pc = t;
        end else if (l) m_pc = t;
        else if (i) m_pc = (m_pc + 1) % 256;
    endtask

    // Apply one cycle of ops, then check one step after the edge.
    task automatic do_op(input bit r, input bit c, input bit l, input bit i,
                         input bit s, input logic [7:0] t, input string tag);
        ret = r; call = c; load = l; inc = i; stall = s; target = t;
        model_step(r, c, l, i, s, t);
        @(posedge clk);
        #1;
        ret = 0; call = 0; load = 0; inc = 0; stall = 0;
        check_all(tag);
    endtask

    // Reset asserted and checked between clock edges, released before the next edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        chk8({tag, "/rv"}, pc, RV);
        #1 rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        chk8("reset_pc", pc, 8'h10);
        #2 rst = 1'b0;

        // Wrap-around
        do_op(0, 0, 1, 0, 0, 8'hFE, "wrap_load");
        chk8("wrap_fe", pc, 8'hFE);
        do_op(0, 0, 0, 1, 0, 8'h00, "wrap_inc1");
        chk8("wrap_ff", pc, 8'hFF);
        do_op(0, 0, 0, 1, 0, 8'h00, "wrap_inc2");
        chk8("wrap_00", pc, 8'h00);
        do_op(0, 0, 0, 1, 0, 8'h00, "wrap_inc3");
        chk8("wrap_01", pc, 8'h01);

        // Nested call/return
        do_op(0, 0, 1, 0, 0, 8'h05, "nest_load");
        do_op(0, 1, 0, 0, 0, 8'h40, "nest_call1");
        chk8("nest_40", pc, 8'h40);
        do_op(0, 1, 0, 0, 0, 8'h80, "nest_call2");
        chk8("nest_80", pc, 8'h80);
        do_op(1, 0, 0, 0, 0, 8'h00, "nest_ret1");
        chk8("nest_41", pc, 8'h41);
        do_op(1, 0, 0, 0, 0, 8'h00, "nest_ret2");
        chk8("nest_06", pc, 8'h06);
        chk1("nest_empty", stack_empty, 1'b1);

        // Priority and stall
        do_op(0, 0, 1, 0, 0, 8'h21, "prio_load");
        do_op(0, 1, 0, 0, 0, 8'h50, "prio_call");
        do_op(1, 1, 0, 1, 0, 8'h99, "prio_all");
        chk8("prio_22", pc, 8'h22);
        for (int k = 0; k < 3; k++) begin
            do_op(0, 0, 0, 1, 1, 8'h00, "stall_inc");
            chk8("stall_22", pc, 8'h22);
        end

        // Asynchronous reset mid-stream, then op on first edge after release
        do_op(0, 1, 0, 0, 0, 8'h70, "mid_call");
        async_reset("mid_rst");
        do_op(0, 0, 0, 1, 0, 8'h00, "post_rst_inc");
        chk8("post_rst_11", pc, 8'h11);

        // Overflow
        async_reset("ovf_rst");
        for (int k = 1; k <= 5; k++) begin
            do_op(0, 1, 0, 0, 0, 8'h30, "ovf_call");
            if (k == 4) chk1("ovf_full4", stack_full, 1'b1);
        end
        chk8("ovf_pc5", pc, 8'h30);
        chk1("ovf_fault5", fault, FAULT_EN);
        do_op(0, 0, 0, 1, 0, 8'h00, "ovf_inc");
        chk8("ovf_after", pc, FAULT_EN ? 8'h30 : 8'h31);

        // Underflow
        async_reset("unf_rst");
        do_op(0, 0, 1, 0, 0, 8'h55, "unf_load");
        do_op(1, 0, 0, 0, 0, 8'h00, "unf_ret");
        chk8("unf_pc", pc, FAULT_EN ? 8'h55 : 8'h10);
        chk1("unf_fault", fault, FAULT_EN);
        do_op(0, 0, 1, 0, 0, 8'hAA, "unf_load2");
        chk8("unf_after", pc, FAULT_EN ? 8'h55 : 8'hAA);
        async_reset("unf_clear");
        chk1("unf_cleared", fault, 1'b0);

        // Randomized ops against the model
        for (int n = 0; n < 400; n++) begin
            if (m_halt && ($urandom_range(0, 3) == 0)) begin
                async_reset("rnd_rst");
            end else begin
                do_op($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25,
                      $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 50,
                      $urandom_range(0, 99) < 10, 8'($urandom_range(0, 255)), "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
